// File: rtl/if_stage_pkg.sv
//==============================================================================
// Module      : if_stage_pkg
// Description : Shared constants for the MIPS instruction-fetch stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package if_stage_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] IM_BASE   = 32'h0000_3000;
    localparam int          IM_DEPTH  = 4096;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    // Cause code reported downstream alongside d_exc.
    localparam logic [4:0]  EXC_ADEL  = 5'd4;

endpackage

`default_nettype wire

// File: rtl/if_stage_pc_reg.sv
//==============================================================================
// Module      : if_stage_pc_reg
// Description : Program counter with async active-low reset, hold and redirect.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module if_stage_pc_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = if_stage_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic [31:0] pc
);

    logic [31:0] r_pc;

    // Sequential PC; +4 wraps modulo 2^32 and redirect targets are taken as-is.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else if (!hold) begin
            r_pc <= redirect ? redirectPc : (r_pc + 32'd4);
        end
    end

    assign pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
//==============================================================================
// Module      : if_stage
// Description : MIPS instruction fetch: PC, IM address and IF/ID register.
//               Optional fetch address check enabled by IF_ADDR_CHECK_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = if_stage_pkg::RESET_PC,
    parameter logic [31:0] IM_BASE  = if_stage_pkg::IM_BASE,
    parameter int          IM_DEPTH = if_stage_pkg::IM_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic [31:0] d_pc8,
    output logic        d_valid,
    output logic        d_exc
);

    logic [31:0] w_pc;
    logic [31:0] w_pcPlus8;
    logic [31:0] w_fetchInstr;
    logic        w_addrErr;

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pc8;
    logic        r_valid;
    logic        r_exc;

    // A flush during stall is exception entry, so the PC must still move.
    if_stage_pc_reg #(
        .RESET_PC   (RESET_PC)
    ) u_pcReg (
        .clk        (clk),
        .reset      (reset),
        .hold       (stall && !flush),
        .redirect   (redirect),
        .redirectPc (redirect_pc),
        .pc         (w_pc)
    );

    assign imem_addr = w_pc;
    assign w_pcPlus8 = w_pc + 32'd8;

`ifdef IF_ADDR_CHECK_EN
    localparam logic [32:0] c_imLimit = {1'b0, IM_BASE} + (33'(IM_DEPTH) << 2);

    assign w_addrErr = (w_pc[1:0] != 2'b00) || (w_pc < IM_BASE) ||
                       ({1'b0, w_pc} >= c_imLimit);

    logic w_unusedParams;
    assign w_unusedParams = ^EXC_ADEL;
`else
    assign w_addrErr = 1'b0;

    logic w_unusedParams;
    assign w_unusedParams = ^{EXC_ADEL, IM_BASE, IM_DEPTH};
`endif

    assign w_fetchInstr = w_addrErr ? NOP_INSTR : imem_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr <= NOP_INSTR;
            r_pc    <= 32'd0;
            r_pc8   <= 32'd0;
            r_valid <= 1'b0;
            r_exc   <= 1'b0;
        end else if (flush) begin
            r_instr <= NOP_INSTR;
            r_pc    <= 32'd0;
            r_pc8   <= 32'd0;
            r_valid <= 1'b0;
            r_exc   <= 1'b0;
        end else if (!stall) begin
            r_instr <= w_fetchInstr;
            r_pc    <= w_pc;
            r_pc8   <= w_pcPlus8;
            r_valid <= 1'b1;
            r_exc   <= w_addrErr;
        end
    end

    assign d_instr = r_instr;
    assign d_pc    = r_pc;
    assign d_pc8   = r_pc8;
    assign d_valid = r_valid;
    assign d_exc   = r_exc;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
//==============================================================================
// Module      : tb_if_stage
// Description : Directed self-checking bench for if_stage (IF_ADDR_CHECK_EN aware).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_if_stage;

`ifdef IF_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [31:0] d_pc8;
    logic        d_valid;
    logic        d_exc;

    int compared = 0;
    int failed   = 0;

    if_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .d_instr     (d_instr),
        .d_pc        (d_pc),
        .d_pc8       (d_pc8),
        .d_valid     (d_valid),
        .d_exc       (d_exc)
    );

    always #5 clk = ~clk;

    // Instruction memory model: fixed word at the reset vector, address-tagged elsewhere.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a == 32'h0000_3000) ? 32'h2408_0001 : (a ^ 32'hDEAD_0000);
    endfunction

    assign imem_rdata = memWord(imem_addr);

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        repeat (3) step();
        compared++; if (imem_addr !== 32'h3000) begin failed++; $display("FAIL reset_addr: got %h want %h", imem_addr, 32'h3000); end
        compared++; if (d_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b want 0", d_valid); end
        compared++; if (d_instr !== 32'h0) begin failed++; $display("FAIL reset_instr: got %h want 0", d_instr); end
        compared++; if (d_pc !== 32'h0 || d_pc8 !== 32'h0) begin failed++; $display("FAIL reset_pc: got %h/%h want 0/0", d_pc, d_pc8); end
        compared++; if (d_exc !== 1'b0) begin failed++; $display("FAIL reset_exc: got %b want 0", d_exc); end
        reset = 1'b1;
        step();
        compared++; if (d_instr !== 32'h2408_0001) begin failed++; $display("FAIL first_instr: got %h want %h", d_instr, 32'h2408_0001); end
        compared++; if (d_pc !== 32'h3000 || d_pc8 !== 32'h3008) begin failed++; $display("FAIL first_pc: got %h/%h want 3000/3008", d_pc, d_pc8); end
        compared++; if (imem_addr !== 32'h3004 || d_valid !== 1'b1) begin failed++; $display("FAIL first_addr: got %h v=%b want 3004 v=1", imem_addr, d_valid); end
    endtask

    task automatic test_redirect();
        step();
        redirect = 1'b1; redirect_pc = 32'h3040;
        step();
        compared++; if (imem_addr !== 32'h3040) begin failed++; $display("FAIL redir_pc: got %h want 3040", imem_addr); end
        compared++; if (d_pc !== 32'h3008 || d_valid !== 1'b1) begin failed++; $display("FAIL redir_slot: got %h v=%b want 3008 v=1", d_pc, d_valid); end
        compared++; if (d_instr !== 32'hDEAD_3008) begin failed++; $display("FAIL redir_slot_instr: got %h want DEAD3008", d_instr); end
        redirect = 1'b0;
        step();
        compared++; if (d_pc !== 32'h3040 || imem_addr !== 32'h3044) begin failed++; $display("FAIL redir_target: got %h/%h want 3040/3044", d_pc, imem_addr); end
    endtask

    task automatic test_stall();
        redirect = 1'b1; redirect_pc = 32'h300C;
        step();
        stall = 1'b1; redirect_pc = 32'h3100;
        for (int i = 0; i < 2; i++) begin
            step();
            compared++; if (imem_addr !== 32'h300C) begin failed++; $display("FAIL stall_pc%0d: got %h want 300c", i, imem_addr); end
            compared++; if (d_pc !== 32'h3044 || d_instr !== 32'hDEAD_3044 || d_pc8 !== 32'h304C) begin failed++; $display("FAIL stall_ifid%0d: got %h/%h/%h", i, d_pc, d_instr, d_pc8); end
        end
        stall = 1'b0;
        step();
        compared++; if (imem_addr !== 32'h3100 || d_pc !== 32'h300C) begin failed++; $display("FAIL stall_release: got %h/%h want 3100/300c", imem_addr, d_pc); end
    endtask

    task automatic test_flush();
        redirect = 1'b1; redirect_pc = 32'h3010;
        step();
        redirect = 1'b0; stall = 1'b1; flush = 1'b1;
        step();
        compared++; if (d_valid !== 1'b0 || d_instr !== 32'h0) begin failed++; $display("FAIL flush_bubble: got v=%b %h want v=0 0", d_valid, d_instr); end
        compared++; if (d_pc !== 32'h0 || d_pc8 !== 32'h0 || d_exc !== 1'b0) begin failed++; $display("FAIL flush_fields: got %h/%h/%b", d_pc, d_pc8, d_exc); end
        compared++; if (imem_addr !== 32'h3014) begin failed++; $display("FAIL flush_pc: got %h want 3014", imem_addr); end
        redirect = 1'b1; redirect_pc = 32'h3200;
        step();
        compared++; if (imem_addr !== 32'h3200 || d_valid !== 1'b0) begin failed++; $display("FAIL flush_redir: got %h v=%b want 3200 v=0", imem_addr, d_valid); end
        redirect = 1'b0; stall = 1'b0; flush = 1'b0;
        step();
        compared++; if (d_pc !== 32'h3200 || d_valid !== 1'b1 || imem_addr !== 32'h3204) begin failed++; $display("FAIL flush_resume: got %h v=%b %h", d_pc, d_valid, imem_addr); end
    endtask

    task automatic test_async_reset();
        redirect = 1'b1; redirect_pc = 32'h3020;
        step();
        redirect = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        compared++; if (imem_addr !== 32'h3000) begin failed++; $display("FAIL async_pc: got %h want 3000", imem_addr); end
        compared++; if (d_valid !== 1'b0 || d_instr !== 32'h0 || d_pc !== 32'h0 || d_pc8 !== 32'h0) begin failed++; $display("FAIL async_ifid: got v=%b %h %h %h", d_valid, d_instr, d_pc, d_pc8); end
        @(negedge clk);
        reset = 1'b1;
        step();
        compared++; if (d_pc !== 32'h3000 || d_instr !== 32'h2408_0001) begin failed++; $display("FAIL async_restart: got %h %h", d_pc, d_instr); end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        step();
        compared++; if (imem_addr !== 32'h0) begin failed++; $display("FAIL wrap_pc: got %h want 0", imem_addr); end
        compared++; if (d_pc !== 32'hFFFF_FFFC || d_pc8 !== 32'h4) begin failed++; $display("FAIL wrap_pc8: got %h/%h want fffffffc/4", d_pc, d_pc8); end
        compared++; if (d_exc !== CHK || d_instr !== (CHK ? 32'h0 : 32'h2152_FFFC)) begin failed++; $display("FAIL wrap_exc: got %b %h", d_exc, d_instr); end
    endtask

    task automatic test_addr_check();
        redirect = 1'b1; redirect_pc = 32'h3002;
        step();
        redirect_pc = 32'h2FFC;
        step();
        compared++; if (imem_addr !== 32'h2FFC || d_pc !== 32'h3002) begin failed++; $display("FAIL misalign_pc: got %h/%h want 2ffc/3002", imem_addr, d_pc); end
        compared++; if (d_exc !== CHK || d_instr !== (CHK ? 32'h0 : 32'hDEAD_3002) || d_valid !== 1'b1) begin failed++; $display("FAIL misalign_exc: got %b %h v=%b", d_exc, d_instr, d_valid); end
        redirect_pc = 32'h6FFC;
        step();
        compared++; if (d_pc !== 32'h2FFC || d_exc !== CHK || d_instr !== (CHK ? 32'h0 : 32'hDEAD_2FFC)) begin failed++; $display("FAIL below_exc: got %h %b %h", d_pc, d_exc, d_instr); end
        redirect = 1'b0;
        step();
        compared++; if (d_pc !== 32'h6FFC || d_exc !== 1'b0 || d_instr !== 32'hDEAD_6FFC) begin failed++; $display("FAIL top_ok: got %h %b %h", d_pc, d_exc, d_instr); end
        stall = 1'b1;
        step();
        compared++; if (d_pc !== 32'h6FFC || imem_addr !== 32'h7000) begin failed++; $display("FAIL stall_hold_chk: got %h %h", d_pc, imem_addr); end
        stall = 1'b0;
        step();
        compared++; if (d_pc !== 32'h7000 || d_exc !== CHK || d_instr !== (CHK ? 32'h0 : 32'hDEAD_7000)) begin failed++; $display("FAIL above_exc: got %h %b %h", d_pc, d_exc, d_instr); end
        flush = 1'b1;
        step();
        compared++; if (d_exc !== 1'b0 || d_valid !== 1'b0) begin failed++; $display("FAIL flush_exc: got %b v=%b want 0 v=0", d_exc, d_valid); end
        flush = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_redirect();
        test_stall();
        test_flush();
        test_async_reset();
        test_wrap();
        test_addr_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

`default_nettype wire
